// File: rtl/ir_nec_command_decoder.sv
// NEC IR frame decoder: measures pulse widths on the conditioned receiver pin, validates
// frames and repeat codes, and maps known keys onto a held 3-bit drive code.
module ir_nec_command_decoder #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter bit          ADDR_CHECK  = 1'b1,
  parameter logic [7:0]  EXPECT_ADDR = 8'h00,
  parameter int unsigned HOLD_MS     = 150,
  parameter logic [7:0]  KEY_STOP    = 8'h1C,
  parameter logic [7:0]  KEY_LEFT    = 8'h08,
  parameter logic [7:0]  KEY_RIGHT   = 8'h5A,
  parameter logic [7:0]  KEY_SLOW    = 8'h52,
  parameter logic [7:0]  KEY_MED     = 8'h18,
  parameter logic [7:0]  KEY_FAST    = 8'h16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_rx,
  output logic [2:0] state_control,
  output logic [7:0] cmd_code,
  output logic       cmd_valid,
  output logic       repeat_valid,
  output logic       frame_error
);

  localparam int unsigned TickDivRaw = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned TickDiv    = (TickDivRaw > 0) ? TickDivRaw : 1;
  localparam int unsigned TickW      = (TickDiv > 1) ? $clog2(TickDiv) : 1;

  localparam logic [15:0] LeadLowMin  = 16'd8000;
  localparam logic [15:0] LeadLowMax  = 16'd10000;
  localparam logic [15:0] LeadDataMin = 16'd4000;
  localparam logic [15:0] LeadDataMax = 16'd5000;
  localparam logic [15:0] LeadRepMin  = 16'd1750;
  localparam logic [15:0] LeadRepMax  = 16'd2750;
  localparam logic [15:0] BurstMin    = 16'd400;
  localparam logic [15:0] BurstMax    = 16'd750;
  localparam logic [15:0] Space0Min   = 16'd400;
  localparam logic [15:0] Space0Max   = 16'd750;
  localparam logic [15:0] Space1Min   = 16'd1400;
  localparam logic [15:0] Space1Max   = 16'd1950;
  localparam logic [15:0] StuckUs     = 16'd12000;
  localparam logic [15:0] HoldInit    = 16'(HOLD_MS);

  typedef enum logic [2:0] {
    StIdle, StLeadLow, StLeadHigh, StBitLow, StBitHigh, StStopLow, StRepStop
  } state_e;

  function automatic logic in_win(input logic [15:0] w, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  logic             sync1_q, sync2_q;
  logic [1:0]       hist_q;
  logic             filt_q, filt_d;
  logic             edge_det, rise, fall;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [9:0]       ms_cnt_q, ms_cnt_d;
  logic             ms_tick;
  logic [15:0]      width_q, width_d;
  logic [15:0]      hold_q, hold_d;
  logic             expire;
  state_e           state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic [7:0]       cmd_code_q, cmd_code_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             repeat_valid_q, repeat_valid_d;
  logic             frame_error_q, frame_error_d;
  logic [2:0]       state_control_q, state_control_d;
  logic             reload, err, frame_ok;

  // Majority over the newest synchronised sample and the two before it.
  always_comb begin
    filt_d   = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    edge_det = filt_d != filt_q;
    rise     = edge_det & filt_d;
    fall     = edge_det & ~filt_d;
  end

  always_comb begin
    tick       = tick_cnt_q == TickW'(TickDiv - 1);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    ms_tick    = tick && (ms_cnt_q == 10'd999);
    ms_cnt_d   = ms_cnt_q;
    if (tick) ms_cnt_d = ms_tick ? 10'd0 : ms_cnt_q + 10'd1;
    if (edge_det)                          width_d = 16'd0;
    else if (tick && width_q != 16'hFFFF)  width_d = width_q + 16'd1;
    else                                   width_d = width_q;
  end

  always_comb begin
    frame_ok = (shift_q[7:0] == ~shift_q[15:8]) && (shift_q[23:16] == ~shift_q[31:24]) &&
               (!ADDR_CHECK || shift_q[7:0] == EXPECT_ADDR);
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    cmd_code_d     = cmd_code_q;
    cmd_valid_d    = 1'b0;
    repeat_valid_d = 1'b0;
    frame_error_d  = 1'b0;
    reload         = 1'b0;
    err            = 1'b0;
    unique case (state_q)
      StIdle: if (fall) state_d = StLeadLow;
      StLeadLow: if (rise) begin
        if (in_win(width_q, LeadLowMin, LeadLowMax)) state_d = StLeadHigh;
        else err = 1'b1;
      end
      StLeadHigh: if (fall) begin
        if (in_win(width_q, LeadDataMin, LeadDataMax)) begin
          state_d   = StBitLow;
          bit_cnt_d = 5'd0;
        end else if (in_win(width_q, LeadRepMin, LeadRepMax)) begin
          state_d = StRepStop;
        end else begin
          err = 1'b1;
        end
      end
      StBitLow: if (rise) begin
        if (in_win(width_q, BurstMin, BurstMax)) state_d = StBitHigh;
        else err = 1'b1;
      end
      StBitHigh: if (fall) begin
        if (in_win(width_q, Space0Min, Space0Max) || in_win(width_q, Space1Min, Space1Max)) begin
          // LSB-first: after 32 shifts the first received bit sits at [0].
          shift_d = {in_win(width_q, Space1Min, Space1Max), shift_q[31:1]};
          if (bit_cnt_q == 5'd31) begin
            state_d = StStopLow;
          end else begin
            state_d   = StBitLow;
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          err = 1'b1;
        end
      end
      StStopLow: if (rise) begin
        if (in_win(width_q, BurstMin, BurstMax) && frame_ok) begin
          cmd_code_d  = shift_q[23:16];
          cmd_valid_d = 1'b1;
          reload      = 1'b1;
          state_d     = StIdle;
        end else begin
          err = 1'b1;
        end
      end
      StRepStop: if (rise) begin
        if (in_win(width_q, BurstMin, BurstMax)) begin
          // A repeat after the hold has lapsed no longer refers to a live key.
          if (hold_q != 16'd0) begin
            repeat_valid_d = 1'b1;
            reload         = 1'b1;
          end
          state_d = StIdle;
        end else begin
          err = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_q != StIdle && !edge_det && width_q >= StuckUs) err = 1'b1;
    if (err) begin
      state_d       = StIdle;
      frame_error_d = 1'b1;
    end
  end

  // Reload from this cycle's FSM event takes priority over expiry.
  always_comb begin
    hold_d = hold_q;
    expire = 1'b0;
    if (reload) begin
      hold_d = HoldInit;
    end else if (ms_tick && hold_q != 16'd0) begin
      hold_d = hold_q - 16'd1;
      expire = hold_q == 16'd1;
    end
    state_control_d = state_control_q;
    if (expire) state_control_d = 3'b000;
    if (cmd_valid_q) begin
      if      (cmd_code_q == KEY_STOP)  state_control_d = 3'b000;
      else if (cmd_code_q == KEY_LEFT)  state_control_d = 3'b001;
      else if (cmd_code_q == KEY_RIGHT) state_control_d = 3'b010;
      else if (cmd_code_q == KEY_SLOW)  state_control_d = 3'b011;
      else if (cmd_code_q == KEY_MED)   state_control_d = 3'b100;
      else if (cmd_code_q == KEY_FAST)  state_control_d = 3'b101;
    end
  end

  // Line-conditioning flops reset to the idle-high level to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      hist_q          <= 2'b11;
      filt_q          <= 1'b1;
      tick_cnt_q      <= '0;
      ms_cnt_q        <= 10'd0;
      width_q         <= 16'd0;
      hold_q          <= 16'd0;
      state_q         <= StIdle;
      bit_cnt_q       <= 5'd0;
      shift_q         <= 32'd0;
      cmd_code_q      <= 8'h00;
      cmd_valid_q     <= 1'b0;
      repeat_valid_q  <= 1'b0;
      frame_error_q   <= 1'b0;
      state_control_q <= 3'b000;
    end else begin
      sync1_q         <= ir_rx;
      sync2_q         <= sync1_q;
      hist_q          <= {hist_q[0], sync2_q};
      filt_q          <= filt_d;
      tick_cnt_q      <= tick_cnt_d;
      ms_cnt_q        <= ms_cnt_d;
      width_q         <= width_d;
      hold_q          <= hold_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      cmd_code_q      <= cmd_code_d;
      cmd_valid_q     <= cmd_valid_d;
      repeat_valid_q  <= repeat_valid_d;
      frame_error_q   <= frame_error_d;
      state_control_q <= state_control_d;
    end
  end

  assign state_control = state_control_q;
  assign cmd_code      = cmd_code_q;
  assign cmd_valid     = cmd_valid_q;
  assign repeat_valid  = repeat_valid_q;
  assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_ir_nec_command_decoder.sv
// Directed bench for ir_nec_command_decoder at 1 MHz, so one clock is one microsecond.
`timescale 1ns / 1ps
module tb_ir_nec_command_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       ir_rx;
  logic [2:0] state_control;
  logic [7:0] cmd_code;
  logic       cmd_valid, repeat_valid, frame_error;

  int unsigned n_checks, n_err;
  int unsigned n_cv = 0, n_rv = 0, n_fe = 0, n_multi = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  cmd;
    logic [31:0] flip;
    int unsigned one_us;
    logic        exp_cv;
    logic        exp_fe;
    logic [2:0]  exp_sc;
    logic [7:0]  exp_code;
  } vec_t;

  ir_nec_command_decoder #(
    .CLK_FREQ_HZ(1_000_000),
    .ADDR_CHECK (1'b1),
    .EXPECT_ADDR(8'h00),
    .HOLD_MS    (150)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ir_rx        (ir_rx),
    .state_control(state_control),
    .cmd_code     (cmd_code),
    .cmd_valid    (cmd_valid),
    .repeat_valid (repeat_valid),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid)    n_cv <= n_cv + 1;
      if (repeat_valid) n_rv <= n_rv + 1;
      if (frame_error)  n_fe <= n_fe + 1;
      if ($countones({cmd_valid, repeat_valid, frame_error}) > 1) n_multi <= n_multi + 1;
    end
  end

  initial begin
    #40_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
             n_checks, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int unsigned act, input int unsigned lo,
                             input int unsigned hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive(input logic v, input int unsigned n);
    ir_rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Leader, 32 bits and the stop burst; leaves the line low at the end of the stop burst.
  task automatic send_body(input logic [7:0] a, input logic [7:0] c, input logic [31:0] flip,
                           input int unsigned one_us);
    logic [31:0] w;
    w = {~c, c, ~a, a} ^ flip;
    drive(1'b0, 9000);
    drive(1'b1, 4500);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 560);
      drive(1'b1, w[i] ? one_us : 560);
    end
    drive(1'b0, 560);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [31:0] flip,
                            input int unsigned one_us);
    send_body(a, c, flip, one_us);
    drive(1'b1, 2000);
  endtask

  task automatic send_repeat();
    drive(1'b0, 9000);
    drive(1'b1, 2250);
    drive(1'b0, 560);
    ir_rx = 1'b1;
  endtask

  task automatic send_bad_space(input int unsigned sp);
    drive(1'b0, 9000);
    drive(1'b1, 4500);
    drive(1'b0, 560);
    drive(1'b1, sp);
    drive(1'b0, 560);
    drive(1'b1, 3000);
  endtask

  initial begin
    vec_t        vecs[8];
    int unsigned b_cv, b_rv, b_fe, k, bad, t0, n;

    vecs[0] = '{8'h00, 8'h52, 32'h0,         1690, 1'b1, 1'b0, 3'b011, 8'h52};
    vecs[1] = '{8'h00, 8'h52, 32'h0100_0000, 1690, 1'b0, 1'b1, 3'b011, 8'h52};
    vecs[2] = '{8'h00, 8'h45, 32'h0,         1690, 1'b1, 1'b0, 3'b011, 8'h45};
    vecs[3] = '{8'h01, 8'h18, 32'h0,         1690, 1'b0, 1'b1, 3'b011, 8'h45};
    vecs[4] = '{8'h00, 8'h1C, 32'h0,         1690, 1'b1, 1'b0, 3'b000, 8'h1C};
    vecs[5] = '{8'h00, 8'h18, 32'h0,         1690, 1'b1, 1'b0, 3'b100, 8'h18};
    vecs[6] = '{8'h00, 8'h5A, 32'h0,         1940, 1'b1, 1'b0, 3'b010, 8'h5A};
    vecs[7] = '{8'h00, 8'h08, 32'h0,         1420, 1'b1, 1'b0, 3'b001, 8'h08};

    n_checks = 0;
    n_err    = 0;
    rst      = 1'b0;
    ir_rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_sc", state_control, 3'b000);
    check("rst_code", cmd_code, 8'h00);
    check("rst_pulses", {cmd_valid, repeat_valid, frame_error}, 3'b000);
    rst = 1'b1;
    drive(1'b1, 3000);

    // Reset in the middle of a frame, then a clean frame.
    drive(1'b0, 9000);
    drive(1'b1, 4500);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 560);
      drive(1'b1, 1690);
    end
    drive(1'b0, 300);
    rst   = 1'b0;
    ir_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 3000);
    b_cv = n_cv;
    b_fe = n_fe;
    send_frame(8'h00, 8'h08, 32'h0, 1690);
    check("midrst_sc", state_control, 3'b001);
    check("midrst_code", cmd_code, 8'h08);
    check("midrst_cv", n_cv - b_cv, 1);
    check("midrst_fe", n_fe - b_fe, 0);

    // Pulse width and state_control latency on a valid frame.
    b_fe = n_fe;
    send_body(8'h00, 8'h5A, 32'h0, 1690);
    ir_rx = 1'b1;
    k = 0;
    while (!cmd_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t_cv_seen", cmd_valid, 1);
    check("t_sc_during_pulse", state_control, 3'b001);
    @(negedge clk);
    check("t_cv_one_cycle", cmd_valid, 0);
    check("t_sc_after_pulse", state_control, 3'b010);
    check("t_code", cmd_code, 8'h5A);
    drive(1'b1, 2000);
    check("t_no_fe", n_fe - b_fe, 0);

    for (int i = 0; i < 8; i++) begin
      b_cv = n_cv;
      b_fe = n_fe;
      send_frame(vecs[i].addr, vecs[i].cmd, vecs[i].flip, vecs[i].one_us);
      check($sformatf("v%0d_cv", i), n_cv - b_cv, 32'(vecs[i].exp_cv));
      check($sformatf("v%0d_fe", i), n_fe - b_fe, 32'(vecs[i].exp_fe));
      check($sformatf("v%0d_sc", i), state_control, 32'(vecs[i].exp_sc));
      check($sformatf("v%0d_code", i), cmd_code, 32'(vecs[i].exp_code));
    end

    // Timing windows that must be rejected.
    b_fe = n_fe;
    drive(1'b0, 7500);
    drive(1'b1, 5000);
    check("lead7500_fe", n_fe - b_fe, 1);
    b_fe = n_fe;
    send_bad_space(1100);
    check("space1100_fe", n_fe - b_fe, 1);
    b_fe = n_fe;
    send_bad_space(1990);
    check("space1990_fe", n_fe - b_fe, 1);
    check("win_sc_kept", state_control, 3'b001);

    // Held key with repeats every 108 ms, then silence.
    t0 = cyc;
    send_body(8'h00, 8'h16, 32'h0, 1690);
    drive(1'b1, 100);
    check("rep_frame_sc", state_control, 3'b101);
    b_rv = n_rv;
    bad  = 0;
    for (int r = 1; r <= 4; r++) begin
      while (cyc < t0 + r * 108000) begin
        @(negedge clk);
        if (state_control != 3'b101) bad++;
      end
      send_repeat();
    end
    n = 0;
    while (state_control != 3'b000 && n < 160000) begin
      @(negedge clk);
      n++;
    end
    check("rep_count", n_rv - b_rv, 4);
    check("rep_sc_held", bad, 0);
    check_range("hold_expiry_us", n, 149000, 151000);
    check("expiry_code_kept", cmd_code, 8'h16);

    // Repeat with the hold lapsed: silently ignored.
    b_rv = n_rv;
    b_fe = n_fe;
    send_repeat();
    drive(1'b1, 2000);
    check("stale_rep_rv", n_rv - b_rv, 0);
    check("stale_rep_fe", n_fe - b_fe, 0);

    // Stuck-low line, then recovery with a clean frame.
    b_fe = n_fe;
    drive(1'b0, 15000);
    drive(1'b1, 2000);
    check("stuck_fe", n_fe - b_fe, 1);
    b_cv = n_cv;
    send_frame(8'h00, 8'h18, 32'h0, 1690);
    check("recover_cv", n_cv - b_cv, 1);
    check("recover_sc", state_control, 3'b100);
    check("recover_code", cmd_code, 8'h18);

    check("no_simultaneous_pulses", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
